ahb_lite_copy_master: RTL

AHB-Lite bus master that copies a block of 32-bit words from a source address range to a destination address range on the system AHB-Lite bus. It drives the master side of the bus (HADDR/HTRANS/HWRITE/HWDATA, samples HREADY/HRDATA/HRESP), so it sits opposite the decoder, slave mux and slaves. It is controlled by a simple START/DONE handshake from a local controller and issues single, non-pipelined NONSEQ word transfers, alternating read and write.

---
 rtl/ahb_lite_copy_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_copy_master.sv
// AHB-Lite word-copy master.
// Copies LEN 32-bit words from SRC to DST using single, non-pipelined
// NONSEQ transfers that alternate read and write. Every bus output is a
// register loaded from the next state, so no bus input reaches an output
// combinationally.
//
// Handshake: the controller pulses START_i while the master is idle. BUSY_o
// rises the next cycle and stays high through the one-cycle DONE_o pulse.
// On the bus, an address phase is accepted on an edge where HTRANS_o is
// NONSEQ and HREADY_i is high. A data phase completes on the edge where
// HREADY_i is high, and HRESP_i is only acted on at that edge.
module ahb_lite_copy_master #(
   parameter int LEN_WIDTH = 16
) (
   input  logic                 HCLK_i,
   input  logic                 HRESETn_i,
   input  logic                 START_i,
   input  logic [31:0]          SRC_i,
   input  logic [31:0]          DST_i,
   input  logic [LEN_WIDTH-1:0] LEN_i,
   output logic                 BUSY_o,
   output logic                 DONE_o,
   output logic                 ERR_o,
   output logic [LEN_WIDTH-1:0] COUNT_o,
   output logic [31:0]          HADDR_o,
   output logic [1:0]           HTRANS_o,
   output logic                 HWRITE_o,
   output logic [2:0]           HSIZE_o,
   output logic [2:0]           HBURST_o,
   output logic [3:0]           HPROT_o,
   output logic                 HMASTLOCK_o,
   output logic [31:0]          HWDATA_o,
   input  logic                 HREADY_i,
   input  logic [31:0]          HRDATA_i,
   input  logic                 HRESP_i,
   output logic [2:0]           dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RA   = 3'd1,
      S_RD   = 3'd2,
      S_WA   = 3'd3,
      S_WD   = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   localparam logic [1:0]           HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]           HTRANS_NONSEQ = 2'b10;
   localparam logic [LEN_WIDTH-1:0] ONE           = LEN_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [31:0]            src_q, src_d;
   logic [31:0]            dst_q, dst_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   count_q, count_d;
   logic [31:0]            data_q, data_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [31:0]            haddr_q, haddr_d;
   logic [1:0]             htrans_q, htrans_d;
   logic                   hwrite_q, hwrite_d;

   // Next-state logic plus the registered bus outputs, derived from the next state.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      count_d  = count_q;
      data_d   = data_q;
      err_d    = err_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      haddr_d  = haddr_q;
      htrans_d = HTRANS_IDLE;
      hwrite_d = 1'b0;

      // BUSY drops the cycle after DONE. A new START accepted in that same
      // idle cycle overrides this below.
      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (START_i) begin
               src_d   = SRC_i & ~32'd3;
               dst_d   = DST_i & ~32'd3;
               len_d   = LEN_i;
               count_d = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = (LEN_i == '0) ? S_FIN : S_RA;
            end
         end
         S_RA: begin
            if (HREADY_i) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (HREADY_i) begin
               if (HRESP_i) begin
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  data_d  = HRDATA_i;
                  state_d = S_WA;
               end
            end
         end
         S_WA: begin
            if (HREADY_i) begin
               state_d = S_WD;
            end
         end
         S_WD: begin
            if (HREADY_i) begin
               if (HRESP_i) begin
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  count_d = count_q + ONE;
                  src_d   = src_q + 32'd4;
                  dst_d   = dst_q + 32'd4;
                  state_d = (count_d == len_q) ? S_FIN : S_RA;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An address phase is on the bus exactly while in RA or WA. HADDR
      // keeps its last value through the following data phase.
      if (state_d == S_RA) begin
         htrans_d = HTRANS_NONSEQ;
         haddr_d  = src_d;
      end else if (state_d == S_WA) begin
         htrans_d = HTRANS_NONSEQ;
         hwrite_d = 1'b1;
         haddr_d  = dst_d;
      end
   end

   // State and output registers. Asynchronous reset returns the bus to IDLE at once.
   always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
      if (!HRESETn_i) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         count_q  <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         haddr_q  <= '0;
         htrans_q <= HTRANS_IDLE;
         hwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         count_q  <= count_d;
         data_q   <= data_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
      end
   end

   assign BUSY_o      = busy_q;
   assign DONE_o      = done_q;
   assign ERR_o       = err_q;
   assign COUNT_o     = count_q;
   assign HADDR_o     = haddr_q;
   assign HTRANS_o    = htrans_q;
   assign HWRITE_o    = hwrite_q;
   assign HWDATA_o    = data_q;
   assign HSIZE_o     = 3'b010;
   assign HBURST_o    = 3'b000;
   assign HPROT_o     = 4'b0011;
   assign HMASTLOCK_o = 1'b0;
   assign dbg_state_o = state_q;

endmodule
